// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-dump transmitter.
// REGDUMP_CHECKSUM_EN adds the trailing XOR checksum state.
package regdump_pkg;

  localparam int REGDUMP_NUM_REGS = 8;
  localparam int REGDUMP_BYTES    = 16;
  localparam logic [7:0] REGDUMP_HDR_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA
`ifdef REGDUMP_CHECKSUM_EN
    , ST_CSUM
`endif
  } regdump_state_t;

endpackage

// File: rtl/regfile_dump_tx_if.sv
// Byte-stream valid/ready link out of the register-dump transmitter.
interface regfile_dump_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/regdump_snap.sv
// 8x16 snapshot bank captured on request, with a byte-select read mux
// (even index = high byte, odd index = low byte of register index/2).
module regdump_snap
  import regdump_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cap,
  input  logic [15:0] r0,
  input  logic [15:0] r1,
  input  logic [15:0] r2,
  input  logic [15:0] r3,
  input  logic [15:0] r4,
  input  logic [15:0] r5,
  input  logic [15:0] r6,
  input  logic [15:0] r7,
  input  logic [3:0]  sel,
  output logic [7:0]  sel_byte
);

  logic [15:0] bank [REGDUMP_NUM_REGS];
  logic [15:0] word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REGDUMP_NUM_REGS; i++) bank[i] <= '0;
    end else if (cap) begin
      bank[0] <= r0;
      bank[1] <= r1;
      bank[2] <= r2;
      bank[3] <= r3;
      bank[4] <= r4;
      bank[5] <= r5;
      bank[6] <= r6;
      bank[7] <= r7;
    end
  end

  always_comb begin
    word     = bank[sel[3:1]];
    sel_byte = sel[0] ? word[7:0] : word[15:8];
  end

endmodule

// File: rtl/regfile_dump_tx.sv
// Debug transmitter: snapshots r0..r7 and streams header + 16 data bytes
// (+ XOR checksum when REGDUMP_CHECKSUM_EN is defined) over valid/ready.
module regfile_dump_tx
  import regdump_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE    = REGDUMP_HDR_DEFAULT,
  parameter int         AUTO_PERIOD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       r0,
  input  logic [15:0]       r1,
  input  logic [15:0]       r2,
  input  logic [15:0]       r3,
  input  logic [15:0]       r4,
  input  logic [15:0]       r5,
  input  logic [15:0]       r6,
  input  logic [15:0]       r7,
  input  logic              trigger,
  regfile_dump_tx_if.master tx,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  regdump_state_t state;
  logic [3:0]     idx;
  logic [31:0]    per_cnt;
  logic           auto_tick;
  logic           req;
  logic           hs;
  logic           last_byte;
  logic           cap;
  logic [3:0]     sel;
  logic [7:0]     snap_byte;
`ifdef REGDUMP_CHECKSUM_EN
  logic [7:0]     csum;
`endif

  always_comb begin
    auto_tick = (AUTO_PERIOD != 0) && (per_cnt == 32'(AUTO_PERIOD - 1));
    req       = trigger | auto_tick;
    hs        = tx.tx_valid & tx.tx_ready;
`ifdef REGDUMP_CHECKSUM_EN
    last_byte = (state == ST_CSUM);
`else
    last_byte = (state == ST_DATA) && (idx == 4'(REGDUMP_BYTES - 1));
`endif
    cap = (state == ST_IDLE) && req;
    // Look ahead one byte so the register is loaded in the handshake cycle
    sel = (state == ST_HDR) ? 4'd0 : 4'(idx + 4'd1);
  end

  regdump_snap u_snap (
    .clk      (clk),
    .rst      (rst),
    .cap      (cap),
    .r0       (r0),
    .r1       (r1),
    .r2       (r2),
    .r3       (r3),
    .r4       (r4),
    .r5       (r5),
    .r6       (r6),
    .r7       (r7),
    .sel      (sel),
    .sel_byte (snap_byte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      tx.tx_data  <= '0;
      tx.tx_valid <= 1'b0;
      busy        <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state       <= ST_HDR;
            idx         <= '0;
            tx.tx_data  <= HDR_BYTE;
            tx.tx_valid <= 1'b1;
            busy        <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
            csum        <= '0;
`endif
          end
        end
        ST_HDR: begin
          if (hs) begin
            state      <= ST_DATA;
            tx.tx_data <= snap_byte;
          end
        end
        ST_DATA: begin
          if (hs) begin
`ifdef REGDUMP_CHECKSUM_EN
            csum <= csum ^ tx.tx_data;
`endif
            if (idx == 4'(REGDUMP_BYTES - 1)) begin
`ifdef REGDUMP_CHECKSUM_EN
              state      <= ST_CSUM;
              tx.tx_data <= csum ^ tx.tx_data;
`else
              state       <= ST_IDLE;
              tx.tx_data  <= '0;
              tx.tx_valid <= 1'b0;
              busy        <= 1'b0;
`endif
            end else begin
              idx        <= 4'(idx + 4'd1);
              tx.tx_data <= snap_byte;
            end
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        ST_CSUM: begin
          if (hs) begin
            state       <= ST_IDLE;
            tx.tx_data  <= '0;
            tx.tx_valid <= 1'b0;
            busy        <= 1'b0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Free-running period counter; never paused by an active frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_cnt <= '0;
    end else if (auto_tick) begin
      per_cnt <= '0;
    end else if (AUTO_PERIOD != 0) begin
      per_cnt <= per_cnt + 32'd1;
    end
  end

  // A request coinciding with the final handshake is not a drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (req && (state != ST_IDLE) && !(hs && last_byte)) begin
      drop_cnt <= sat_inc8(drop_cnt);
    end
  end

endmodule
